// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter between the fetch unit and the loader/debug port.
// The loader has priority; a saturating streak counter bounds how long fetch can be starved.
module imem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 65536,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  logic [SW-1:0] streak;
  logic          streak_full;
  logic          l_in, f_in;
  logic          rsp_v, rsp_owner, rsp_err;

  assign streak_full = (streak == SW'(MAX_STREAK));
  assign l_in        = (l_addr < LIMIT);
  assign f_in        = (f_addr < LIMIT);

  // Loader wins unless fetch has been waiting through a full streak.
  assign l_gnt = !rst && l_req && !(f_req && streak_full);
  assign f_gnt = !rst && f_req && !l_gnt;

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (l_gnt) begin
      if (l_in) begin
        m_en    = 1'b1;
        m_we    = l_we;
        m_addr  = l_addr;
        m_wdata = l_wdata;
      end
    end else if (f_gnt && f_in) begin
      m_en    = 1'b1;
      m_addr  = f_addr;
      m_wdata = l_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak    <= '0;
      rsp_v     <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_v     <= (l_gnt && !l_we) || f_gnt;
      rsp_owner <= l_gnt;
      rsp_err   <= l_gnt ? !l_in : !f_in;
      if (!f_req || f_gnt)
        streak <= '0;
      else if (l_gnt && !streak_full)
        streak <= streak + SW'(1);
    end
  end

  // Out-of-range reads return zero data with err set.
  assign f_rvalid = rsp_v && !rsp_owner;
  assign l_rvalid = rsp_v && rsp_owner;
  assign f_rdata  = (f_rvalid && !rsp_err) ? m_rdata : '0;
  assign l_rdata  = (l_rvalid && !rsp_err) ? m_rdata : '0;
  assign f_err    = f_rvalid && rsp_err;
  assign l_err    = (l_rvalid && rsp_err) || (l_gnt && l_we && !l_in);

endmodule
